// File: rtl/lsu.sv
// Load/store unit: byte-addressed requests onto a word memory, with two-cycle
// handling of accesses that straddle a word boundary.
module lsu #(
  parameter int AWIDTH = 10,
  parameter int DWIDTH = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [AWIDTH+1:0] req_addr,
  input  logic [DWIDTH-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DWIDTH-1:0] resp_rdata,
  output logic              resp_err,
  output logic              dmem_en,
  output logic [3:0]        dmem_wbe,
  output logic [AWIDTH-1:0] dmem_addr,
  output logic [DWIDTH-1:0] dmem_din,
  input  logic [DWIDTH-1:0] dmem_dout
);

  typedef enum logic {IDLE, SECOND} state_t;

  state_t              state;
  logic [AWIDTH-1:0]   lat_addr;
  logic [1:0]          lat_off;
  logic [1:0]          lat_size;
  logic                lat_unsigned;
  logic                lat_we;
  logic [3:0]          lat_wbe;
  logic [DWIDTH-1:0]   lat_din;
  logic [DWIDTH-1:0]   lat_first;

  logic [1:0]          off;
  logic [AWIDTH-1:0]   word_addr;
  logic                legal;
  logic                split;
  logic                accept;
  logic [3:0]          lane_mask;
  logic [7:0]          mask8;
  logic [2*DWIDTH-1:0] sdata;
  logic [DWIDTH-1:0]   ld_low;

  function automatic logic [31:0] extend(input logic [31:0] w, input logic [1:0] sz,
                                         input logic uns);
    logic [31:0] r;
    case (sz)
      2'd0:    r = uns ? {24'h0, w[7:0]}  : {{24{w[7]}}, w[7:0]};
      2'd1:    r = uns ? {16'h0, w[15:0]} : {{16{w[15]}}, w[15:0]};
      default: r = w;
    endcase
    return r;
  endfunction

  assign off       = req_addr[1:0];
  assign word_addr = req_addr[AWIDTH+1:2];
  assign legal     = (req_size != 2'd3);
  assign split     = ((req_size == 2'd1) && (off == 2'd3)) || ((req_size == 2'd2) && (off != 2'd0));
  assign req_ready = (state == IDLE) && !rst;
  assign accept    = req_valid && req_ready;

  always_comb begin
    case (req_size)
      2'd0:    lane_mask = 4'b0001;
      2'd1:    lane_mask = 4'b0011;
      default: lane_mask = 4'b1111;
    endcase
  end

  assign mask8 = {4'b0000, lane_mask} << off;
  assign sdata = {{DWIDTH{1'b0}}, req_wdata} << {off, 3'b000};

  // Load window: in SECOND the latched first word sits below the live second word.
  always_comb begin
    if (state == SECOND)
      ld_low = DWIDTH'({dmem_dout, lat_first} >> {lat_off, 3'b000});
    else
      ld_low = DWIDTH'({{DWIDTH{1'b0}}, dmem_dout} >> {off, 3'b000});
  end

  always_comb begin
    dmem_en   = 1'b0;
    dmem_wbe  = 4'b0000;
    dmem_din  = '0;
    dmem_addr = word_addr;
    if (state == SECOND) begin
      dmem_addr = lat_addr + AWIDTH'(1);
      if (lat_we && !rst) begin
        dmem_en  = 1'b1;
        dmem_wbe = lat_wbe;
        dmem_din = lat_din;
      end
    end else if (req_valid && req_we && legal && !rst) begin
      dmem_en  = 1'b1;
      dmem_wbe = mask8[3:0];
      dmem_din = sdata[DWIDTH-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      resp_valid   <= 1'b0;
      resp_err     <= 1'b0;
      resp_rdata   <= '0;
      lat_addr     <= '0;
      lat_off      <= 2'd0;
      lat_size     <= 2'd0;
      lat_unsigned <= 1'b0;
      lat_we       <= 1'b0;
      lat_wbe      <= 4'b0000;
      lat_din      <= '0;
      lat_first    <= '0;
    end else begin
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
      if (state == IDLE) begin
        if (accept) begin
          if (!legal) begin
            resp_valid <= 1'b1;
            resp_err   <= 1'b1;
          end else if (split) begin
            lat_addr     <= word_addr;
            lat_off      <= off;
            lat_size     <= req_size;
            lat_unsigned <= req_unsigned;
            lat_we       <= req_we;
            lat_wbe      <= mask8[7:4];
            lat_din      <= sdata[2*DWIDTH-1:DWIDTH];
            lat_first    <= dmem_dout;
            state        <= SECOND;
          end else begin
            resp_valid <= 1'b1;
            resp_rdata <= req_we ? '0 : extend(ld_low, req_size, req_unsigned);
          end
        end
      end else begin
        resp_valid <= 1'b1;
        resp_rdata <= lat_we ? '0 : extend(ld_low, lat_size, lat_unsigned);
        state      <= IDLE;
      end
    end
  end

endmodule

// File: tb/tb_lsu.sv
// Bench for lsu: byte-array reference memory, directed scenarios and random traffic.
module tb_lsu;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_we = 1'b0;
  logic [1:0]    req_size = 2'd0;
  logic          req_unsigned = 1'b0;
  logic [AW+1:0] req_addr = '0;
  logic [31:0]   req_wdata = '0;
  logic          resp_valid;
  logic [31:0]   resp_rdata;
  logic          resp_err;
  logic          dmem_en;
  logic [3:0]    dmem_wbe;
  logic [AW-1:0] dmem_addr;
  logic [31:0]   dmem_din;
  logic [31:0]   dmem_dout;

  lsu #(.AWIDTH(AW), .DWIDTH(32)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
    .resp_rdata(resp_rdata), .resp_err(resp_err), .dmem_en(dmem_en),
    .dmem_wbe(dmem_wbe), .dmem_addr(dmem_addr), .dmem_din(dmem_din),
    .dmem_dout(dmem_dout)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:1023];
  logic [7:0]  ref_mem [0:4095];

  assign dmem_dout = mem[dmem_addr];
  always @(posedge clk)
    if (dmem_en)
      for (int b = 0; b < 4; b++)
        if (dmem_wbe[b]) mem[dmem_addr][8*b +: 8] <= dmem_din[8*b +: 8];

  int checks = 0;
  int failures = 0;

  logic          c_en [2];
  logic [3:0]    c_wbe [2];
  logic [AW-1:0] c_addr [2];
  logic [31:0]   c_din [2];
  logic          c_ready1;
  int            c_lat;
  logic [31:0]   c_rdata;
  logic          c_err;

  function automatic logic [31:0] ref_load(input logic [11:0] addr, input logic [1:0] size,
                                           input logic uns);
    int n = 1 << size;
    logic [31:0] v = 0;
    for (int i = 0; i < n; i++) v[8*i +: 8] = ref_mem[(int'(addr) + i) % 4096];
    if (!uns && v[8*n-1])
      for (int k = 8*n; k < 32; k++) v[k] = 1'b1;
    return v;
  endfunction

  function automatic void ref_store(input logic [11:0] addr, input logic [1:0] size,
                                    input logic [31:0] data);
    int n = 1 << size;
    for (int i = 0; i < n; i++) ref_mem[(int'(addr) + i) % 4096] = data[8*i +: 8];
  endfunction

  // Issues one request at posedge+1 and returns one cycle after the response.
  task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                        input logic [11:0] addr, input logic [31:0] wdata);
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    #2;
    checks++;
    if (req_ready !== 1'b1) begin
      failures++; $display("FAIL accept_ready got=%b want=1", req_ready);
    end
    c_en[0] = dmem_en; c_wbe[0] = dmem_wbe; c_addr[0] = dmem_addr; c_din[0] = dmem_din;
    @(posedge clk); #1;
    req_valid = 1'b0; req_we = 1'b0;
    #1;
    c_en[1] = dmem_en; c_wbe[1] = dmem_wbe; c_addr[1] = dmem_addr; c_din[1] = dmem_din;
    c_ready1 = req_ready;
    c_lat = 0;
    for (int k = 1; k <= 4; k++) begin
      if (resp_valid === 1'b1) begin
        c_lat = k; c_rdata = resp_rdata; c_err = resp_err;
        break;
      end
      @(posedge clk); #2;
    end
    checks++;
    if (c_lat == 0) begin
      failures++; $display("FAIL resp_timeout got=none want=resp_valid within 4 cycles");
      c_rdata = 'x; c_err = 1'bx;
    end
    @(posedge clk); #2;
    checks++;
    if (resp_valid !== 1'b0) begin
      failures++; $display("FAIL resp_pulse_width got=%b want=0", resp_valid);
    end
    #9;
  endtask

  task automatic test_reset();
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_addr = 12'h010; req_wdata = 32'hA5A5A5A5;
    @(posedge clk); @(posedge clk); #2;
    checks++;
    if (req_ready !== 1'b0 || resp_valid !== 1'b0 || dmem_en !== 1'b0 || dmem_wbe !== 4'b0 ||
        dmem_din !== 32'h0 || resp_rdata !== 32'h0 || resp_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs got ready=%b rv=%b en=%b wbe=%h din=%h rd=%h err=%b want all 0",
               req_ready, resp_valid, dmem_en, dmem_wbe, dmem_din, resp_rdata, resp_err);
    end
    req_valid = 1'b0; req_we = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    checks++;
    if (req_ready !== 1'b1) begin
      failures++; $display("FAIL ready_after_reset got=%b want=1", req_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_word_roundtrip();
    do_req(1'b1, 2'd2, 1'b0, 12'h008, 32'hDEADBEEF);
    ref_store(12'h008, 2'd2, 32'hDEADBEEF);
    checks++;
    if (c_en[0] !== 1'b1 || c_wbe[0] !== 4'b1111 || c_addr[0] !== 10'd2 || c_din[0] !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL word_store_bus got en=%b wbe=%b addr=%0d din=%h want 1 1111 2 deadbeef",
               c_en[0], c_wbe[0], c_addr[0], c_din[0]);
    end
    do_req(1'b0, 2'd2, 1'b0, 12'h008, 32'h0);
    checks++;
    if (c_lat != 1 || c_rdata !== 32'hDEADBEEF || c_err !== 1'b0) begin
      failures++;
      $display("FAIL word_load got lat=%0d rdata=%h err=%b want 1 deadbeef 0", c_lat, c_rdata, c_err);
    end
  endtask

  task automatic test_byte_ext();
    do_req(1'b1, 2'd0, 1'b0, 12'h005, 32'h00000080);
    ref_store(12'h005, 2'd0, 32'h80);
    checks++;
    if (c_wbe[0] !== 4'b0010 || c_din[0] !== 32'h00008000 || c_addr[0] !== 10'd1) begin
      failures++;
      $display("FAIL byte_store_bus got wbe=%b din=%h addr=%0d want 0010 00008000 1",
               c_wbe[0], c_din[0], c_addr[0]);
    end
    do_req(1'b0, 2'd0, 1'b0, 12'h005, 32'h0);
    checks++;
    if (c_rdata !== 32'hFFFFFF80) begin
      failures++; $display("FAIL byte_load_signed got=%h want=ffffff80", c_rdata);
    end
    do_req(1'b0, 2'd0, 1'b1, 12'h005, 32'h0);
    checks++;
    if (c_rdata !== 32'h00000080) begin
      failures++; $display("FAIL byte_load_unsigned got=%h want=00000080", c_rdata);
    end
  endtask

  task automatic test_split_store();
    do_req(1'b1, 2'd2, 1'b0, 12'h003, 32'h11223344);
    ref_store(12'h003, 2'd2, 32'h11223344);
    checks++;
    if (c_en[0] !== 1'b1 || c_addr[0] !== 10'd0 || c_wbe[0] !== 4'b1000 || c_din[0] !== 32'h44000000) begin
      failures++;
      $display("FAIL split_first_bus got en=%b addr=%0d wbe=%b din=%h want 1 0 1000 44000000",
               c_en[0], c_addr[0], c_wbe[0], c_din[0]);
    end
    checks++;
    if (c_en[1] !== 1'b1 || c_addr[1] !== 10'd1 || c_wbe[1] !== 4'b0111 ||
        c_din[1] !== 32'h00112233 || c_ready1 !== 1'b0) begin
      failures++;
      $display("FAIL split_second_bus got en=%b addr=%0d wbe=%b din=%h ready=%b want 1 1 0111 00112233 0",
               c_en[1], c_addr[1], c_wbe[1], c_din[1], c_ready1);
    end
    checks++;
    if (c_lat != 2 || c_rdata !== 32'h0) begin
      failures++; $display("FAIL split_store_resp got lat=%0d rdata=%h want 2 0", c_lat, c_rdata);
    end
    do_req(1'b0, 2'd2, 1'b0, 12'h003, 32'h0);
    checks++;
    if (c_lat != 2 || c_rdata !== 32'h11223344) begin
      failures++; $display("FAIL split_load got lat=%0d rdata=%h want 2 11223344", c_lat, c_rdata);
    end
  endtask

  task automatic test_top_wrap();
    mem[1023][31:24] = 8'h34; ref_mem[4095] = 8'h34;
    mem[0][7:0]      = 8'h82; ref_mem[0]    = 8'h82;
    do_req(1'b0, 2'd1, 1'b0, 12'hFFF, 32'h0);
    checks++;
    if (c_addr[0] !== 10'd1023 || c_addr[1] !== 10'd0 || c_en[0] !== 1'b0 || c_en[1] !== 1'b0) begin
      failures++;
      $display("FAIL wrap_addr got a0=%0d a1=%0d en=%b%b want 1023 0 00", c_addr[0], c_addr[1], c_en[0], c_en[1]);
    end
    checks++;
    if (c_lat != 2 || c_rdata !== 32'hFFFF8234) begin
      failures++; $display("FAIL wrap_load got lat=%0d rdata=%h want 2 ffff8234", c_lat, c_rdata);
    end
  endtask

  task automatic test_back_to_back();
    logic [11:0] a [4];
    logic [1:0]  s [4];
    logic        u [4];
    logic [31:0] e [4];
    for (int i = 0; i < 4; i++) begin
      s[i] = 2'($urandom_range(0, 2));
      a[i] = {$urandom_range(0, 1023), 2'b00} + 12'(($urandom_range(0, 3) >> s[i]) << s[i]);
      u[i] = 1'($urandom_range(0, 1));
      e[i] = ref_load(a[i], s[i], u[i]);
    end
    for (int j = 0; j <= 4; j++) begin
      if (j < 4) begin
        req_valid = 1'b1; req_we = 1'b0; req_size = s[j]; req_unsigned = u[j]; req_addr = a[j];
      end else begin
        req_valid = 1'b0;
      end
      #2;
      if (j < 4) begin
        checks++;
        if (req_ready !== 1'b1) begin
          failures++; $display("FAIL b2b_ready idx=%0d got=%b want=1", j, req_ready);
        end
      end
      if (j > 0) begin
        checks++;
        if (resp_valid !== 1'b1 || resp_rdata !== e[j-1] || resp_err !== 1'b0) begin
          failures++;
          $display("FAIL b2b_resp idx=%0d got v=%b rdata=%h want 1 %h", j-1, resp_valid, resp_rdata, e[j-1]);
        end
      end
      @(posedge clk); #1;
    end
    #1;
    checks++;
    if (resp_valid !== 1'b0) begin
      failures++; $display("FAIL b2b_tail got=%b want=0", resp_valid);
    end
    #9;
  endtask

  task automatic test_illegal();
    for (int w = 0; w < 2; w++) begin
      do_req(1'(w), 2'd3, 1'b0, 12'(12'h040 + w), 32'hCAFEF00D);
      checks++;
      if (c_lat != 1 || c_err !== 1'b1 || c_rdata !== 32'h0 || c_en[0] !== 1'b0 || c_en[1] !== 1'b0) begin
        failures++;
        $display("FAIL illegal_size we=%0d got lat=%0d err=%b rdata=%h en=%b%b want 1 1 0 00",
                 w, c_lat, c_err, c_rdata, c_en[0], c_en[1]);
      end
    end
  endtask

  task automatic test_random();
    int bad = 0;
    for (int i = 0; i < 300; i++) begin
      logic        we   = 1'($urandom_range(0, 1));
      logic [1:0]  sz   = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      logic        uns  = 1'($urandom_range(0, 1));
      logic [11:0] ad   = ($urandom_range(0, 7) == 0) ? 12'($urandom_range(4092, 4095)) : 12'($urandom);
      logic [31:0] wd   = $urandom;
      logic        ill  = (sz == 2'd3);
      int          n    = ill ? 0 : (1 << sz);
      int          lat  = (!ill && (int'(ad[1:0]) + n > 4)) ? 2 : 1;
      logic [31:0] er   = (we || ill) ? 32'h0 : ref_load(ad, sz, uns);
      do_req(we, sz, uns, ad, wd);
      if (we && !ill) ref_store(ad, sz, wd);
      checks++;
      if (c_lat != lat || c_rdata !== er || c_err !== ill) begin
        failures++; bad++;
        if (bad < 5)
          $display("FAIL random_resp i=%0d we=%b sz=%0d addr=%h got lat=%0d rdata=%h err=%b want %0d %h %b",
                   i, we, sz, ad, c_lat, c_rdata, c_err, lat, er, ill);
      end
    end
  endtask

  task automatic test_mem_image(input string tag);
    int bad = 0;
    int first = -1;
    for (int w = 0; w < 1024; w++)
      if (mem[w] !== {ref_mem[4*w+3], ref_mem[4*w+2], ref_mem[4*w+1], ref_mem[4*w]}) begin
        bad++;
        if (first < 0) first = w;
      end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL mem_image_%s got %0d differing words (first %0d: %h) want 0 (ref %h)",
               tag, bad, first, mem[first],
               {ref_mem[4*first+3], ref_mem[4*first+2], ref_mem[4*first+1], ref_mem[4*first]});
    end
  endtask

  task automatic test_reset_split();
    int seen = 0;
    logic [31:0] wd = $urandom;
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_unsigned = 1'b0;
    req_addr = 12'h011; req_wdata = wd;
    #2;
    checks++;
    if (req_ready !== 1'b1 || dmem_wbe !== 4'b1110) begin
      failures++; $display("FAIL rst_split_first got ready=%b wbe=%b want 1 1110", req_ready, dmem_wbe);
    end
    // Only bytes 1..3 of word 4 are committed before the abort.
    for (int i = 0; i < 3; i++) ref_mem[12'h011 + i] = wd[8*i +: 8];
    @(posedge clk); #1;
    req_valid = 1'b0; req_we = 1'b0;
    checks++;
    if (req_ready !== 1'b0 || dmem_en !== 1'b1) begin
      failures++; $display("FAIL rst_split_second got ready=%b en=%b want 0 1", req_ready, dmem_en);
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    if (dmem_en !== 1'b0 || resp_valid !== 1'b0 || req_ready !== 1'b0) begin
      failures++;
      $display("FAIL rst_split_abort got en=%b rv=%b ready=%b want 0 0 0", dmem_en, resp_valid, req_ready);
    end
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #2;
      if (resp_valid === 1'b1) seen++;
      if (k == 1) begin
        rst = 1'b0;
        #1;
        checks++;
        if (req_ready !== 1'b1) begin
          failures++; $display("FAIL rst_split_ready got=%b want=1", req_ready);
        end
      end
    end
    checks++;
    if (seen != 0) begin
      failures++; $display("FAIL rst_split_noresp got=%0d pulses want=0", seen);
    end
    @(posedge clk); #1;
    test_mem_image("after_reset");
  endtask

  initial begin
    for (int w = 0; w < 1024; w++) begin
      logic [31:0] v = $urandom;
      mem[w] = v;
      for (int b = 0; b < 4; b++) ref_mem[4*w+b] = v[8*b +: 8];
    end
    test_reset();
    test_word_roundtrip();
    test_byte_ext();
    test_split_store();
    test_top_wrap();
    test_back_to_back();
    test_illegal();
    test_random();
    test_mem_image("after_random");
    test_reset_split();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lsu.md
# lsu

Load/store unit between the core's memory stage and the word-organised data memory (async read, sync byte-masked write, word address). It takes byte-addressed load/store requests (byte, half, word; signed or unsigned), produces the per-lane write byte enables and lane-shifted write data, and extracts and extends load data. Accesses that cross a word boundary are split into two memory cycles by a small FSM, with a registered response.

## Interface
- `AWIDTH`, default 10: data memory word-address width; the byte address is `AWIDTH+2` bits.
- `DWIDTH`, default 32: data width; only 32 is supported.
- `clk`, in, 1: clock, rising edge.
- `rst`, in, 1: reset, asynchronous, active-high.
- `req_valid`, in, 1: request present.
- `req_ready`, out, 1: request accepted on a cycle when `req_valid && req_ready`.
- `req_we`, in, 1: 1 = store, 0 = load.
- `req_size`, in, 2: 0 = byte, 1 = half, 2 = word, 3 = illegal.
- `req_unsigned`, in, 1: load zero-extends when 1, sign-extends when 0.
- `req_addr`, in, AWIDTH+2: byte address.
- `req_wdata`, in, 32: store data, right-aligned.
- `resp_valid`, out, 1: one-cycle response pulse; no backpressure.
- `resp_rdata`, out, 32: extended load data; 0 for stores and errors.
- `resp_err`, out, 1: qualified by `resp_valid`; set for an illegal size.
- `dmem_en`, out, 1: memory write enable.
- `dmem_wbe`, out, 4: byte write enables.
- `dmem_addr`, out, AWIDTH: word address.
- `dmem_din`, out, 32: lane-aligned write data.
- `dmem_dout`, in, 32: memory read data, combinational from `dmem_addr`.

## Operation
- **FSM states:** IDLE, SECOND.
- **`req_ready`:** equals (state == IDLE) && !rst.
- **Access geometry:** offset o = `req_addr[1:0]`, length n = 1/2/4 bytes. The access spans bytes o..o+n-1 of a 64-bit window {word A+1, word A}, where A = `req_addr[AWIDTH+1:2]`.
- **Split rule:** the access is split iff o+n > 4, i.e. half at o = 3, or word at o = 1..3.
- **Store mask and data:** 8-bit mask M = ((1<<n)-1) << o and 64-bit data S = `req_wdata` << 8o. The first access uses M[3:0] and S[31:0]; the second uses M[7:4] and S[63:32].
- **Load data:** W = {second word, first word} >> 8o. Take the low n bytes, then zero-extend (`req_unsigned`) or sign-extend from bit 8n-1.
- **IDLE:** `dmem_addr` = A combinationally from the request. `dmem_en` = `req_valid && req_we && size legal`, with `dmem_wbe` = M[3:0] and `dmem_din` = S[31:0].
  - Non-split access: on accept, register the result and go to IDLE (a new request can be accepted next cycle).
  - Split access: latch A, o, n, unsigned, we, S[63:32], M[7:4] and `dmem_dout` (the first word), then go to SECOND.
- **SECOND:** `dmem_addr` = A+1, wrapping modulo 2^AWIDTH (last word wraps to word 0). `dmem_en` = latched we, with the latched upper mask and data. Assemble the response and return to IDLE.
- **`dmem_wbe` / `dmem_din` when no write:** both 0 whenever `dmem_en` = 0.
- **Illegal size:** accepted, no memory write, and `resp_valid` = 1 with `resp_err` = 1 and `resp_rdata` = 0 the next cycle.
- **Reset:** reset in SECOND aborts the access. The second half is not written; a first half already written stays written. No response is issued.

## Timing
- **While `rst` is high:** state = IDLE; `resp_valid`, `resp_err`, `resp_rdata`, `dmem_en`, `dmem_wbe` and `dmem_din` are 0; `req_ready` is 0.
- **Non-split access:** accepted in cycle t, memory written at the t→t+1 edge, `resp_valid` high in cycle t+1.
- **Split access:** accepted in cycle t, second access in t+1, `resp_valid` high in t+2. `req_ready` is 0 in t+1.
- **Throughput:** one non-split request per cycle; a split request occupies two cycles.
- **Response registers:** `resp_*` are registered and hold their value for exactly one cycle.

## Test plan
- **Word store/load round trip:** store word 0xDEADBEEF to addr 0x8; `dmem_wbe`=4'b1111 and `dmem_addr`=2. Then load word from 0x8 → `resp_rdata`=0xDEADBEEF one cycle after accept.
- **Byte store and extension:** store byte 0x80 to addr 0x5 → `dmem_wbe`=4'b0010 and `dmem_din`=0x00008000. A signed byte load from 0x5 gives 0xFFFFFF80; an unsigned load gives 0x00000080.
- **Split word store:** store word 0x11223344 to addr 0x3. Cycle t: addr 0, wbe 4'b1000, din 0x44000000. Cycle t+1: addr 1, wbe 4'b0111, din 0x00112233, `req_ready`=0. Response in t+2. A load word from 0x3 returns 0x11223344.
- **Split at the top of memory:** signed half load from byte address 0xFFF (AWIDTH=10) with mem[1023][31:24]=0x34 and mem[0][7:0]=0x82 → second access at word 0, `resp_rdata`=0xFFFF8234.
- **Back-to-back and illegal:** four aligned loads on consecutive cycles → four consecutive `resp_valid` pulses in order. A size-3 request → `resp_err`=1, `resp_rdata`=0, and `dmem_en` never asserted.
- **Reset mid-split:** assert `rst` during SECOND of a split store → no response; only the first-half bytes change in memory; `req_ready`=1 the first cycle after `rst` drops.
